mem_stage: RTL

- MEM stage of the 5-stage RV32I pipeline. It sits between the ex_mem pipeline register and the mem_wb register.
- Consumes the registered EX results (rd, regwe, result, loadctl, storectl, storedata).
- Performs byte/half/word loads and stores over a req/ack data-memory bus and sign/zero-extends load data.
- Requests a pipeline stall from the stall controller while a memory access is outstanding.

---
 rtl/mem_stage.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: byte/half/word loads and stores over a req/ack
// data bus, with load extension and a stall request while an access is in flight.
module mem_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        rd_i,
   input  logic              regwe_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic [2:0]        loadctl_i,
   input  logic [2:0]        storectl_i,
   input  logic [DATA_W-1:0] storedata_i,
   input  logic [5:0]        stall_i,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [4:0]        rd_o,
   output logic              regwe_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              stallreq_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [31:0]       mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [3:0]        mem_be_o,
   output logic              misalign_o
);

   localparam logic [31:0] ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << ADDR_W) - 32'd1);

   localparam logic [2:0] LD_LB  = 3'd1;
   localparam logic [2:0] LD_LH  = 3'd2;
   localparam logic [2:0] LD_LW  = 3'd3;
   localparam logic [2:0] LD_LBU = 3'd4;
   localparam logic [2:0] LD_LHU = 3'd5;
   localparam logic [2:0] ST_SB  = 3'd1;
   localparam logic [2:0] ST_SH  = 3'd2;
   localparam logic [2:0] ST_SW  = 3'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0]        sc,
                                                     input logic [DATA_W-1:0] d);
      case (sc)
         ST_SB:   return {4{d[7:0]}};
         ST_SH:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic       ld,
                                               input logic [2:0] sc,
                                               input logic [1:0] off);
      if (ld) return 4'b1111;
      case (sc)
         ST_SB:   return 4'b0001 << off;
         ST_SH:   return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] load_extract(input logic [2:0]        lc,
                                                      input logic [DATA_W-1:0] w,
                                                      input logic [1:0]        off);
      logic        [7:0]        b;
      logic        [15:0]       h;
      logic signed [7:0]        bs;
      logic signed [15:0]       hs;
      logic signed [DATA_W-1:0] sx;
      b  = w[{off, 3'b000} +: 8];
      h  = w[{off[1], 4'b0000} +: 16];
      bs = signed'(b);
      hs = signed'(h);
      case (lc)
         LD_LB:   sx = DATA_W'(bs);
         LD_LH:   sx = DATA_W'(hs);
         LD_LBU:  sx = signed'(DATA_W'(b));
         LD_LHU:  sx = signed'(DATA_W'(h));
         LD_LW:   sx = signed'(w);
         default: sx = '0;
      endcase
      return unsigned'(sx);
   endfunction

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
   logic [2:0]        ldctl_q, ldctl_d;
   logic [1:0]        off_q, off_d;

   logic [31:0] addr;
   logic        is_load, is_store, access;
   logic        half_acc, word_acc, misalign;
   logic        unused_stall;

   assign addr     = result_i & ADDR_MASK;
   assign is_load  = (loadctl_i >= LD_LB) && (loadctl_i <= LD_LHU);
   assign is_store = !is_load && (storectl_i >= ST_SB) && (storectl_i <= ST_SW);
   assign access   = is_load || is_store;
   assign half_acc = (is_load && ((loadctl_i == LD_LH) || (loadctl_i == LD_LHU)))
                  || (is_store && (storectl_i == ST_SH));
   assign word_acc = (is_load && (loadctl_i == LD_LW)) || (is_store && (storectl_i == ST_SW));
   assign misalign = (half_acc && addr[0]) || (word_acc && (addr[1:0] != 2'b00));

   assign misalign_o   = misalign;
   assign unused_stall = ^{stall_i[5], stall_i[3:0]};

   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rdata_buf_d = rdata_buf_q;
      ldctl_d     = ldctl_q;
      off_d       = off_q;
      rd_o        = rd_i;
      regwe_o     = regwe_i;
      wdata_o     = result_i;
      stallreq_o  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (misalign) begin
               regwe_o = 1'b0;
               wdata_o = '0;
            end else if (access) begin
               stallreq_o = 1'b1;
               regwe_o    = 1'b0;
               wdata_o    = '0;
               req_d      = 1'b1;
               we_d       = is_store;
               addr_d     = {addr[31:2], 2'b00};
               wdata_d    = store_lanes(is_store ? storectl_i : 3'd0, storedata_i);
               be_d       = byte_enables(is_load, storectl_i, addr[1:0]);
               ldctl_d    = is_load ? loadctl_i : 3'd0;
               off_d      = addr[1:0];
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            stallreq_o = 1'b1;
            regwe_o    = 1'b0;
            wdata_o    = '0;
            if (mem_ack_i) begin
               rdata_buf_d = load_extract(ldctl_q, mem_rdata_i, off_q);
               req_d       = 1'b0;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            // ex_mem is held while MEM is stalled, so regwe_i/rd_i still belong to this access
            if (ldctl_q != 3'd0) begin
               wdata_o = rdata_buf_q;
            end else begin
               regwe_o = 1'b0;
            end
            if (!stall_i[4]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rdata_buf_q <= '0;
         ldctl_q     <= '0;
         off_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rdata_buf_q <= rdata_buf_d;
         ldctl_q     <= ldctl_d;
         off_q       <= off_d;
      end
   end

endmodule
